// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, completion, flush and retire signals of the reorder buffer
interface reorder_buffer_if #(
  parameter int PTR_W = 4,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
);
  logic alloc_valid;
  logic alloc_ready;
  logic [AREG_W-1:0] alloc_rd;
  logic [PREG_W-1:0] alloc_phys_rd;
  logic [PREG_W-1:0] alloc_old_phys_rd;
  logic alloc_reg_write;
  logic [PTR_W-1:0] alloc_tag;
  logic cmpl_valid;
  logic [PTR_W-1:0] cmpl_tag;
  logic flush;
  logic commit_valid;
  logic retire_valid;
  logic [PREG_W-1:0] retire_phys_reg;
  logic [AREG_W-1:0] retire_rd;
  logic [PREG_W-1:0] retire_new_phys;
  logic rob_empty;
  logic rob_full;
  logic [PTR_W:0] rob_count;
  modport master (
    output alloc_valid, alloc_rd, alloc_phys_rd, alloc_old_phys_rd, alloc_reg_write,
           cmpl_valid, cmpl_tag, flush,
    input  alloc_ready, alloc_tag, commit_valid, retire_valid, retire_phys_reg,
           retire_rd, retire_new_phys, rob_empty, rob_full, rob_count
  );
  modport slave (
    input  alloc_valid, alloc_rd, alloc_phys_rd, alloc_old_phys_rd, alloc_reg_write,
           cmpl_valid, cmpl_tag, flush,
    output alloc_ready, alloc_tag, commit_valid, retire_valid, retire_phys_reg,
           retire_rd, retire_new_phys, rob_empty, rob_full, rob_count
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement with out-of-order completion; ROB_CMPL_BYPASS_EN lets a completing head retire on the same edge
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
) (
  input logic clk,
  input logic reset_n,
  reorder_buffer_if.slave rob
);
  logic [DEPTH-1:0] valid, done, reg_write;
  logic [AREG_W-1:0] rd [DEPTH];
  logic [PREG_W-1:0] phys_rd [DEPTH];
  logic [PREG_W-1:0] old_phys_rd [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0] count;
  logic do_alloc, do_cmpl, head_done, do_retire;
  assign rob.alloc_ready = count != (PTR_W+1)'(DEPTH);
  assign rob.alloc_tag = tail;
  assign rob.rob_empty = count == '0;
  assign rob.rob_full = count == (PTR_W+1)'(DEPTH);
  assign rob.rob_count = count;
  always_comb begin
    do_alloc = rob.alloc_valid && rob.alloc_ready;
    do_cmpl = rob.cmpl_valid && valid[rob.cmpl_tag] && !(do_alloc && rob.cmpl_tag == tail);
`ifdef ROB_CMPL_BYPASS_EN
    head_done = done[head] || (do_cmpl && rob.cmpl_tag == head);
`else
    head_done = done[head];
`endif
    do_retire = valid[head] && head_done;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      rob.commit_valid <= 1'b0;
      rob.retire_valid <= 1'b0;
      rob.retire_phys_reg <= '0;
      rob.retire_rd <= '0;
      rob.retire_new_phys <= '0;
    end else if (rob.flush) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      rob.commit_valid <= 1'b0;
      rob.retire_valid <= 1'b0;
    end else begin
      if (do_alloc) begin
        valid[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail <= tail + PTR_W'(1);
      end
      if (do_cmpl) done[rob.cmpl_tag] <= 1'b1;
      if (do_retire) begin
        valid[head] <= 1'b0;
        head <= head + PTR_W'(1);
        rob.retire_phys_reg <= old_phys_rd[head];
        rob.retire_rd <= rd[head];
        rob.retire_new_phys <= phys_rd[head];
      end
      count <= count + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(do_retire);
      rob.commit_valid <= do_retire;
      rob.retire_valid <= do_retire && reg_write[head];
    end
  end
  // payload is only meaningful while valid is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      reg_write[tail] <= rob.alloc_reg_write;
      rd[tail] <= rob.alloc_rd;
      phys_rd[tail] <= rob.alloc_phys_rd;
      old_phys_rd[tail] <= rob.alloc_old_phys_rd;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench; allocations push expected retirements, commit pulses pop and compare
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  reorder_buffer_if #(.PTR_W(4), .AREG_W(5), .PREG_W(6)) rob_if ();
  reorder_buffer #(.DEPTH(16), .PTR_W(4), .AREG_W(5), .PREG_W(6)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rob(rob_if)
  );
  typedef struct packed {
    logic rw;
    logic [4:0] rd;
    logic [5:0] phys;
    logic [5:0] old;
  } ent_t;
  ent_t sb[$];
  int tests = 0;
  int fails = 0;
  logic [3:0] tl, cp, t0;
  int acc_n;
  bit ok, cv;
`ifdef ROB_CMPL_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic ent_t mk(input int rw, input int rd, input int phys, input int old);
    return ent_t'{1'(rw), 5'(rd), 6'(phys), 6'(old)};
  endfunction
  // advance one edge, then retire-check against the scoreboard
  task automatic cyc;
    ent_t e;
    @(posedge clk);
    #1;
    if (rob_if.commit_valid) begin
      if (sb.size() == 0) chk("commit_unexp", 32'(rob_if.commit_valid), 0);
      else begin
        e = sb.pop_front();
        chk("retire_valid", 32'(rob_if.retire_valid), 32'(e.rw));
        chk("retire_phys_reg", 32'(rob_if.retire_phys_reg), 32'(e.old));
        chk("retire_rd", 32'(rob_if.retire_rd), 32'(e.rd));
        chk("retire_new_phys", 32'(rob_if.retire_new_phys), 32'(e.phys));
      end
    end
    chk("count", 32'(rob_if.rob_count), 32'(sb.size()));
  endtask
  task automatic drive(input bit av, input ent_t d, input bit c, input logic [3:0] ct, input bit fl);
    bit acc;
    acc = av && !fl && sb.size() < 16;
    rob_if.alloc_valid = av;
    rob_if.alloc_rd = d.rd;
    rob_if.alloc_phys_rd = d.phys;
    rob_if.alloc_old_phys_rd = d.old;
    rob_if.alloc_reg_write = d.rw;
    rob_if.cmpl_valid = c;
    rob_if.cmpl_tag = ct;
    rob_if.flush = fl;
    if (av) begin
      chk("alloc_tag", 32'(rob_if.alloc_tag), 32'(tl));
      chk("alloc_ready", 32'(rob_if.alloc_ready), 32'(sb.size() < 16));
    end
    if (fl) begin
      sb.delete();
      tl = '0;
    end else if (acc) begin
      sb.push_back(d);
      tl++;
    end
    cyc();
    rob_if.alloc_valid = 1'b0;
    rob_if.cmpl_valid = 1'b0;
    rob_if.flush = 1'b0;
  endtask
  task automatic alloc(input ent_t d);
    drive(1'b1, d, 1'b0, 4'd0, 1'b0);
  endtask
  task automatic cmpl(input logic [3:0] t);
    drive(1'b0, ent_t'(0), 1'b1, t, 1'b0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    reset_n = 1'b0;
    rob_if.alloc_valid = 1'b0;
    rob_if.alloc_rd = '0;
    rob_if.alloc_phys_rd = '0;
    rob_if.alloc_old_phys_rd = '0;
    rob_if.alloc_reg_write = 1'b0;
    rob_if.cmpl_valid = 1'b0;
    rob_if.cmpl_tag = '0;
    rob_if.flush = 1'b0;
    tl = '0;
    cp = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_tag", 32'(rob_if.alloc_tag), 0);
    chk("rst_ready", 32'(rob_if.alloc_ready), 1);
    chk("rst_empty", 32'(rob_if.rob_empty), 1);
    chk("rst_full", 32'(rob_if.rob_full), 0);
    chk("rst_count", 32'(rob_if.rob_count), 0);
    chk("rst_commit", 32'(rob_if.commit_valid), 0);
    chk("rst_retire", 32'(rob_if.retire_valid), 0);
    chk("rst_phys", 32'(rob_if.retire_phys_reg), 0);
    chk("rst_rd", 32'(rob_if.retire_rd), 0);
    chk("rst_new", 32'(rob_if.retire_new_phys), 0);
    for (int i = 0; i < 3; i++) alloc(mk(1, i + 1, 33 + i, i + 1));
    for (int i = 0; i < 3; i++) cmpl(4'(i));
    repeat (4) cyc();
    chk("inorder_empty", 32'(rob_if.rob_empty), 1);
    for (int i = 0; i < 3; i++) alloc(mk(1, 4 + i, 36 + i, 4 + i));
    cmpl(4'd5);
    cmpl(4'd4);
    chk("ooo_hold", 32'(rob_if.commit_valid), 0);
    cyc();
    chk("ooo_hold2", 32'(rob_if.commit_valid), 0);
    cmpl(4'd3);
    chk("head_lat", 32'(rob_if.commit_valid), 32'(LAT == 0));
    if (LAT != 0) cyc();
    for (int i = 0; i < 3; i++) begin
      chk("ooo_pulse", 32'(rob_if.commit_valid), 1);
      cyc();
    end
    chk("ooo_end", 32'(rob_if.commit_valid), 0);
    alloc(mk(1, 7, 40, 7));
    cmpl(4'd7);
    for (int i = 0; i < 3; i++) begin
      chk("inv_cmpl", 32'(rob_if.commit_valid), 0);
      cyc();
    end
    cmpl(4'd6);
    repeat (3) cyc();
    drive(1'b1, mk(1, 8, 41, 8), 1'b1, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("same_cyc_cmpl", 32'(rob_if.commit_valid), 0);
      cyc();
    end
    cmpl(4'd7);
    repeat (3) cyc();
    alloc(mk(0, 9, 42, 9));
    cmpl(4'd8);
    if (LAT != 0) cyc();
    chk("nowrite_commit", 32'(rob_if.commit_valid), 1);
    chk("nowrite_retire", 32'(rob_if.retire_valid), 0);
    repeat (2) cyc();
    for (int i = 0; i < 16; i++) alloc(mk(1, i, $urandom_range(63), $urandom_range(63)));
    chk("full", 32'(rob_if.rob_full), 1);
    chk("full_ready", 32'(rob_if.alloc_ready), 0);
    chk("full_empty", 32'(rob_if.rob_empty), 0);
`ifndef ROB_CMPL_BYPASS_EN
    cmpl(4'd9);
`endif
    drive(1'b1, mk(1, 20, 60, 20), 1'b1, 4'd9, 1'b0);
    chk("full_ret_count", 32'(rob_if.rob_count), 15);
    chk("full_ret_tail", 32'(rob_if.alloc_tag), 9);
    cp = 4'd10;
    acc_n = 0;
    for (int k = 0; k < 60 && acc_n < 20; k++) begin
      ok = sb.size() < 16;
      cv = cp != tl;
      drive(1'b1, mk(1, k, $urandom_range(63), $urandom_range(63)), cv, cp, 1'b0);
      if (cv) cp++;
      if (ok) acc_n++;
    end
    chk("wrap_pairs", 32'(acc_n), 20);
    for (int k = 0; k < 17 && cp != tl; k++) begin
      cmpl(cp);
      cp++;
    end
    for (int k = 0; k < 40 && sb.size() != 0; k++) cyc();
    chk("wrap_drain", 32'(sb.size()), 0);
    t0 = tl;
    for (int i = 0; i < 5; i++) alloc(mk(1, 10 + i, 50 + i, 10 + i));
    cmpl(t0 + 4'd1);
    drive(1'b0, ent_t'(0), 1'b1, t0, 1'b1);
    cp = '0;
    chk("flush_empty", 32'(rob_if.rob_empty), 1);
    chk("flush_commit", 32'(rob_if.commit_valid), 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("flush_quiet", 32'(rob_if.commit_valid), 0);
    end
    alloc(mk(1, 3, 50, 3));
    cmpl(4'd0);
    repeat (3) cyc();
    chk("final_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
